// File: rtl/gj_elim_sequencer_pkg.sv
// Shared types and helpers for the Gauss-Jordan sequencer: FSM state encoding,
// row-operation codes and index-width helpers.
package gj_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LDRAIN,
        ST_PIVOT,
        ST_FWD,
        ST_BACK,
        ST_NORM,
        ST_STORE,
        ST_DONE
    } gj_state_e;

    localparam logic [1:0] OP_ELIM = 2'd0;
    localparam logic [1:0] OP_NORM = 2'd1;

    localparam int GJ_N_DEFAULT = 5;

    // Row index width; kept at least 1 bit so a degenerate order still elaborates.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Column index width for the 2N-wide augmented matrix.
    function automatic int col_w(input int n);
        return (n > 0) ? $clog2(2 * n) : 1;
    endfunction

endpackage

// File: rtl/gj_elim_sequencer_if.sv
// Host/RAM/datapath signal bundle of the Gauss-Jordan sequencer.
// master = the sequencer, slave = the host/datapath side.
interface gj_elim_sequencer_if
    import gj_pkg::*;
#(
    parameter int N  = GJ_N_DEFAULT,
    parameter int AW = 6
);
    localparam int RW = row_w(N);
    localparam int CW = col_w(N);

    logic          start;
    logic          busy;
    logic          done;
    logic          singular;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic          ld_valid;
    logic [RW-1:0] el_row;
    logic [CW-1:0] el_col;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_kind;
    logic [RW-1:0] op_pivot;
    logic [RW-1:0] op_target;
    logic          piv_zero;

    modport master (
        input  start, op_ready, piv_zero,
        output busy, done, singular, mem_addr, mem_re, mem_we, ld_valid,
               el_row, el_col, op_valid, op_kind, op_pivot, op_target
    );

    modport slave (
        output start, op_ready, piv_zero,
        input  busy, done, singular, mem_addr, mem_re, mem_we, ld_valid,
               el_row, el_col, op_valid, op_kind, op_pivot, op_target
    );

endinterface

// File: rtl/gj_elim_sequencer_idx_counter.sv
// Row-major element walker: row/column indices plus a RAM address that
// advance together. Shared by the load and store phases.
module gj_idx_counter #(
    parameter int ROWS = 5,
    parameter int COLS = 10,
    parameter int AW   = 6,
    parameter int RW   = 3,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          last
);

    // Restart at element [0][0] on load, otherwise step one element per enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (load) begin
            row  <= '0;
            col  <= '0;
            addr <= load_addr;
        end else if (en) begin
            addr <= addr + 1'b1;
            if (col == CW'(COLS - 1)) begin
                col <= '0;
                row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Flags the final element so the FSM can leave the phase on this cycle.
    assign last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

endmodule

// File: rtl/gj_elim_sequencer.sv
// Gauss-Jordan inverse control sequencer: loads the N x 2N augmented matrix,
// checks pivots, issues forward/back elimination and normalisation row ops,
// then stores the result. No arithmetic happens here.
module gj_elim_sequencer
    import gj_pkg::*;
#(
    parameter int N       = GJ_N_DEFAULT,
    parameter int AW      = 6,
    parameter int LD_BASE = 1,
    parameter int ST_BASE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    gj_elim_sequencer_if.master   bus
);

    localparam int RW   = row_w(N);
    localparam int CW   = col_w(N);
    localparam int COLS = 2 * N;

    // The address counter must never wrap inside a job.
    generate
        if (N < 2 || (2 ** AW) < LD_BASE + N * COLS || (2 ** AW) < ST_BASE + N * COLS) begin : g_bad_params
            $error("gj_elim_sequencer: illegal N/AW/LD_BASE/ST_BASE combination");
        end
    endgenerate

    gj_state_e     state_q, state_d;
    logic [RW-1:0] p_q, p_d;
    logic [RW-1:0] t_q, t_d;
    logic          sing_q;
    logic          sing_set, sing_clr;

    logic          cnt_load, cnt_en, cnt_last;
    logic [AW-1:0] cnt_load_addr, cnt_addr;
    logic [RW-1:0] cnt_row;
    logic [CW-1:0] cnt_col;

    logic          ld_valid_q;
    logic [RW-1:0] ld_row_q;
    logic [CW-1:0] ld_col_q;

    logic          mem_re, mem_we, op_valid;
    logic [AW-1:0] mem_addr;
    logic [1:0]    op_kind;
    logic [RW-1:0] op_pivot, op_target;

    gj_idx_counter #(
        .ROWS (N),
        .COLS (COLS),
        .AW   (AW),
        .RW   (RW),
        .CW   (CW)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_addr (cnt_load_addr),
        .en        (cnt_en),
        .row       (cnt_row),
        .col       (cnt_col),
        .addr      (cnt_addr),
        .last      (cnt_last)
    );

    // State, op-schedule counters and the sticky singular flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            t_q     <= '0;
            sing_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            t_q     <= t_d;
            if (sing_clr)
                sing_q <= 1'b0;
            else if (sing_set)
                sing_q <= 1'b1;
        end
    end

    // Load capture strobe and element index trail the RAM read by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_valid_q <= 1'b0;
            ld_row_q   <= '0;
            ld_col_q   <= '0;
        end else begin
            ld_valid_q <= mem_re;
            ld_row_q   <= cnt_row;
            ld_col_q   <= cnt_col;
        end
    end

    // Next-state, op schedule and RAM/op outputs.
    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        t_d           = t_q;
        sing_set      = 1'b0;
        sing_clr      = 1'b0;
        cnt_load      = 1'b0;
        cnt_load_addr = '0;
        cnt_en        = 1'b0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        op_valid      = 1'b0;
        op_kind       = OP_ELIM;
        op_pivot      = '0;
        op_target     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sing_clr      = 1'b1;
                    cnt_load      = 1'b1;
                    cnt_load_addr = AW'(LD_BASE);
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_re   = 1'b1;
                mem_addr = cnt_addr;
                cnt_en   = 1'b1;
                if (cnt_last)
                    state_d = ST_LDRAIN;
            end
            ST_LDRAIN: begin
                p_d     = '0;
                state_d = ST_PIVOT;
            end
            ST_PIVOT: begin
                op_pivot = p_q;
                if (bus.piv_zero) begin
                    sing_set = 1'b1;
                    state_d  = ST_DONE;
                end else if (p_q == RW'(N - 1)) begin
                    t_d     = p_q - 1'b1;
                    state_d = ST_BACK;
                end else begin
                    t_d     = p_q + 1'b1;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                op_valid  = 1'b1;
                op_pivot  = p_q;
                op_target = t_q;
                if (bus.op_ready) begin
                    if (t_q == RW'(N - 1)) begin
                        p_d     = p_q + 1'b1;
                        state_d = ST_PIVOT;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            ST_BACK: begin
                op_valid  = 1'b1;
                op_pivot  = p_q;
                op_target = t_q;
                if (bus.op_ready) begin
                    if (t_q == '0) begin
                        if (p_q == RW'(1)) begin
                            t_d     = '0;
                            state_d = ST_NORM;
                        end else begin
                            p_d = p_q - 1'b1;
                            t_d = p_d - 1'b1;
                        end
                    end else begin
                        t_d = t_q - 1'b1;
                    end
                end
            end
            ST_NORM: begin
                op_valid  = 1'b1;
                op_kind   = OP_NORM;
                op_pivot  = t_q;
                op_target = t_q;
                if (bus.op_ready) begin
                    if (t_q == RW'(N - 1)) begin
                        cnt_load      = 1'b1;
                        cnt_load_addr = AW'(ST_BASE);
                        state_d       = ST_STORE;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            ST_STORE: begin
                mem_we   = 1'b1;
                mem_addr = cnt_addr;
                cnt_en   = 1'b1;
                if (cnt_last)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.singular  = sing_q;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.ld_valid  = ld_valid_q;
    assign bus.el_row    = mem_we ? cnt_row : (ld_valid_q ? ld_row_q : '0);
    assign bus.el_col    = mem_we ? cnt_col : (ld_valid_q ? ld_col_q : '0);
    assign bus.op_valid  = op_valid;
    assign bus.op_kind   = op_kind;
    assign bus.op_pivot  = op_pivot;
    assign bus.op_target = op_target;

endmodule

// File: tb/tb_gj_elim_sequencer.sv
// Directed bench for gj_elim_sequencer: N=5 job scenarios from a table, plus
// held-start, mid-job reset and an N=2 instance.
module tb_gj_elim_sequencer;
    import gj_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gj_elim_sequencer_if #(.N(5), .AW(6)) bus5 ();
    gj_elim_sequencer_if #(.N(2), .AW(4)) bus2 ();

    gj_elim_sequencer #(.N(5), .AW(6), .LD_BASE(1), .ST_BASE(0)) dut5 (
        .clk (clk), .rst (rst), .bus (bus5)
    );
    gj_elim_sequencer #(.N(2), .AW(4), .LD_BASE(1), .ST_BASE(0)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    typedef struct {
        int zero_p;      // pivot row reported as zero, -1 for none
        int stall_at;    // op index held off by op_ready=0, -1 for none
        int stall_len;
        int exp_ops;
        int exp_writes;
        int exp_stalls;
        bit exp_sing;
    } scen_t;

    // kind*100 + pivot*10 + target
    int exp_ops5 [25] = '{1, 2, 3, 4, 12, 13, 14, 23, 24, 34,
                          43, 42, 41, 40, 32, 31, 30, 21, 20, 10,
                          100, 111, 122, 133, 144};
    int exp_ops2 [4]  = '{1, 10, 100, 111};

    int checks = 0;
    int errors = 0;

    int zero_p    = -1;
    int stall_at  = -1;
    int stall_len = 0;

    int rd_q[$];
    int op_q[$];
    int wr_q[$];
    int ld_cnt, lag_err, wr_err, hold_err, stall_seen, done_cnt;

    int rd2_n, rd2_err, ld2_n, ld2_err, wr2_n, wr2_err, done2;
    int op2_q[$];

    assign bus5.piv_zero = (zero_p >= 0) && (int'(bus5.op_pivot) == zero_p);
    assign bus2.piv_zero = 1'b0;
    assign bus2.op_ready = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs5();
        return int'({bus5.busy, bus5.done, bus5.singular, bus5.mem_addr, bus5.mem_re,
                     bus5.mem_we, bus5.ld_valid, bus5.el_row, bus5.el_col, bus5.op_valid,
                     bus5.op_kind, bus5.op_pivot, bus5.op_target});
    endfunction

    function automatic int outs2();
        return int'({bus2.busy, bus2.done, bus2.singular, bus2.mem_addr, bus2.mem_re,
                     bus2.mem_we, bus2.ld_valid, bus2.el_row, bus2.el_col, bus2.op_valid,
                     bus2.op_kind, bus2.op_pivot, bus2.op_target});
    endfunction

    task automatic clear_mon();
        rd_q.delete(); op_q.delete(); wr_q.delete();
        ld_cnt = 0; lag_err = 0; wr_err = 0; hold_err = 0; stall_seen = 0; done_cnt = 0;
    endtask

    // op_ready: hold off the selected op for stall_len cycles.
    initial begin
        bus5.op_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus5.op_ready = !((stall_at >= 0) && (op_q.size() == stall_at) && (stall_seen < stall_len));
        end
    end

    // N=5 monitor, sampled on the falling edge.
    initial begin
        logic prev_re, prev_stall;
        int   prev_addr, prev_code, code;
        prev_re = 1'b0; prev_stall = 1'b0; prev_addr = 0; prev_code = 0;
        forever begin
            @(negedge clk);
            if (bus5.mem_re) rd_q.push_back(int'(bus5.mem_addr));
            if (bus5.ld_valid) begin
                ld_cnt++;
                if (!prev_re || (int'(bus5.el_row) * 10 + int'(bus5.el_col) != prev_addr - 1))
                    lag_err++;
            end
            code = int'(bus5.op_kind) * 100 + int'(bus5.op_pivot) * 10 + int'(bus5.op_target);
            if (prev_stall && (!bus5.op_valid || code != prev_code)) hold_err++;
            if (bus5.op_valid && bus5.op_ready) op_q.push_back(code);
            if (bus5.op_valid && !bus5.op_ready) stall_seen++;
            if (bus5.mem_we) begin
                wr_q.push_back(int'(bus5.mem_addr));
                if (int'(bus5.el_row) * 10 + int'(bus5.el_col) != int'(bus5.mem_addr)) wr_err++;
            end
            if (bus5.done) done_cnt++;
            prev_re    = bus5.mem_re;
            prev_addr  = int'(bus5.mem_addr);
            prev_stall = bus5.op_valid && !bus5.op_ready;
            prev_code  = code;
        end
    end

    // N=2 monitor.
    initial begin
        logic prev_re2;
        prev_re2 = 1'b0;
        rd2_n = 0; rd2_err = 0; ld2_n = 0; ld2_err = 0; wr2_n = 0; wr2_err = 0; done2 = 0;
        forever begin
            @(negedge clk);
            if (bus2.mem_re) begin
                if (int'(bus2.mem_addr) != 1 + rd2_n) rd2_err++;
                rd2_n++;
            end
            if (bus2.ld_valid) begin
                if (!prev_re2 || int'(bus2.el_row) * 4 + int'(bus2.el_col) != ld2_n) ld2_err++;
                ld2_n++;
            end
            if (bus2.op_valid)
                op2_q.push_back(int'(bus2.op_kind) * 100 + int'(bus2.op_pivot) * 10 + int'(bus2.op_target));
            if (bus2.mem_we) begin
                if (int'(bus2.mem_addr) != wr2_n || int'(bus2.el_row) * 4 + int'(bus2.el_col) != wr2_n)
                    wr2_err++;
                wr2_n++;
            end
            if (bus2.done) done2++;
            prev_re2 = bus2.mem_re;
        end
    end

    task automatic wait_done5(input string name);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check({name, "_timeout"}, int'(cyc >= 2000), 0);
    endtask

    task automatic run_job(input string name, input scen_t s);
        int bad;
        zero_p = s.zero_p; stall_at = s.stall_at; stall_len = s.stall_len;
        clear_mon();
        @(posedge clk); #1;
        bus5.start = 1'b1;
        @(posedge clk); #1;
        bus5.start = 1'b0;
        check({name, "_busy_after_start"}, int'(bus5.busy), 1);
        check({name, "_sing_cleared"}, int'(bus5.singular), 0);
        wait_done5(name);
        #1;
        check({name, "_busy_after_done"}, int'(bus5.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_reads"}, rd_q.size(), 50);
        bad = 0;
        foreach (rd_q[k]) if (rd_q[k] != 1 + k) bad++;
        check({name, "_read_addr_errs"}, bad, 0);
        check({name, "_ld_valid_cnt"}, ld_cnt, 50);
        check({name, "_ld_lag_errs"}, lag_err, 0);
        check({name, "_ops"}, op_q.size(), s.exp_ops);
        bad = 0;
        foreach (op_q[k]) if (k >= 25 || op_q[k] != exp_ops5[k]) bad++;
        check({name, "_op_order_errs"}, bad, 0);
        check({name, "_hold_errs"}, hold_err, 0);
        check({name, "_stall_cycles"}, stall_seen, s.exp_stalls);
        check({name, "_writes"}, wr_q.size(), s.exp_writes);
        bad = wr_err;
        foreach (wr_q[k]) if (wr_q[k] != k) bad++;
        check({name, "_write_addr_errs"}, bad, 0);
        check({name, "_singular"}, int'(bus5.singular), int'(s.exp_sing));
        check({name, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        scen_t scen [6];
        scen_t normal;
        int    cyc;

        scen[0] = '{zero_p: -1, stall_at: -1, stall_len: 0, exp_ops: 25, exp_writes: 50, exp_stalls: 0, exp_sing: 1'b0};
        scen[1] = '{zero_p: -1, stall_at:  6, stall_len: 3, exp_ops: 25, exp_writes: 50, exp_stalls: 3, exp_sing: 1'b0};
        scen[2] = '{zero_p:  2, stall_at: -1, stall_len: 0, exp_ops:  7, exp_writes:  0, exp_stalls: 0, exp_sing: 1'b1};
        scen[3] = '{zero_p:  0, stall_at: -1, stall_len: 0, exp_ops:  0, exp_writes:  0, exp_stalls: 0, exp_sing: 1'b1};
        scen[4] = '{zero_p:  4, stall_at: -1, stall_len: 0, exp_ops: 10, exp_writes:  0, exp_stalls: 0, exp_sing: 1'b1};
        scen[5] = '{zero_p: -1, stall_at: -1, stall_len: 0, exp_ops: 25, exp_writes: 50, exp_stalls: 0, exp_sing: 1'b0};
        normal  = scen[0];

        rst = 1'b1;
        bus5.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_n5", outs5(), 0);
        check("reset_outputs_n2", outs2(), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_job($sformatf("scen%0d", i), scen[i]);

        // start held high across a whole job and its DONE cycle
        clear_mon();
        zero_p = -1; stall_at = -1;
        @(posedge clk); #1;
        bus5.start = 1'b1;
        wait_done5("held");
        #1;
        check("held_idle_gap_busy", int'(bus5.busy), 0);
        check("held_idle_gap_re", int'(bus5.mem_re), 0);
        check("held_first_job_reads", rd_q.size(), 50);
        check("held_first_job_ops", op_q.size(), 25);
        check("held_first_job_writes", wr_q.size(), 50);
        check("held_done_pulses", done_cnt, 1);
        @(posedge clk); #1;
        bus5.start = 1'b0;
        check("held_second_job_busy", int'(bus5.busy), 1);
        check("held_second_job_addr", int'(bus5.mem_re) * 100 + int'(bus5.mem_addr), 101);

        // reset while the second job is in forward elimination
        clear_mon();
        cyc = 0;
        while (op_q.size() < 2 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check("fwd_reach_timeout", int'(cyc >= 2000), 0);
        #3;
        rst = 1'b1;
        #1;
        check("reset_mid_job_outputs", outs5(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        repeat (5) @(posedge clk);
        #1;
        check("no_activity_after_reset", rd_q.size() + op_q.size() + wr_q.size() + done_cnt, 0);
        run_job("after_reset", normal);

        // N=2 instance
        op2_q.delete();
        @(posedge clk); #1;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        cyc = 0;
        while (done2 == 0 && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        check("n2_timeout", int'(cyc >= 1000), 0);
        repeat (2) @(posedge clk);
        #1;
        check("n2_reads", rd2_n, 8);
        check("n2_read_errs", rd2_err, 0);
        check("n2_ld_cnt", ld2_n, 8);
        check("n2_ld_errs", ld2_err, 0);
        check("n2_ops", op2_q.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < op2_q.size()) check($sformatf("n2_op%0d", k), op2_q[k], exp_ops2[k]);
        check("n2_writes", wr2_n, 8);
        check("n2_write_errs", wr2_err, 0);
        check("n2_singular", int'(bus2.singular), 0);
        check("n2_done_pulses", done2, 1);
        check("n2_idle", int'(bus2.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
